tri_vertex_feeder: RTL and testbench
====================================

Name: tri_vertex_feeder

Overview:
- Initiator side of the triangle-rendering vertex interface (nt/xi/yi/busy).
- Accepts whole triangles from an upstream producer over a valid/ready handshake and buffers them in a small FIFO.
- Issues each triangle to the rendering engine as one nt-flagged 3-cycle vertex burst.
- Paces bursts on the engine's busy signal.

Parameters:
- COORD_W, 3, bits per coordinate (x and y each).
- DEPTH, 4, FIFO depth in triangles; power of 2, at least 2.
- BUSY_TIMEOUT, 255, max cycles in WAIT_HI for busy to rise; 8-bit counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream triangle valid.
- in_ready  output  1  FIFO can accept a triangle.
- in_tri  input  6*COORD_W  packed {x1,y1,x2,y2,x3,y3}, x1 in MSBs.
- busy  input  1  engine busy, from the rendering engine.
- nt  output  1  new-triangle strobe, high during the vertex-1 cycle only.
- xi  output  COORD_W  vertex x.
- yi  output  COORD_W  vertex y.
- fifo_cnt  output  clog2(DEPTH)+1  triangles buffered.
- idle  output  1  FSM in IDLE and FIFO empty.
- timeout_err  output  1  sticky; busy never rose after a burst.

Behaviour:
- Reset values (asynchronous, while reset=0): nt=0, xi=0, yi=0, in_ready=1, fifo_cnt=0, idle=1, timeout_err=0, FSM=IDLE, FIFO emptied. Reset mid-burst aborts the burst; no partial triangle resumes.
- FIFO:
  - in_ready = !full, from registered state.
  - Push on rising edge when in_valid && in_ready.
  - Pop on the IDLE->V1 transition.
  - When full, a push is refused even if a pop happens the same cycle.
  - Simultaneous push and pop when not full: fifo_cnt unchanged.
  - Pointers wrap modulo DEPTH.
- FSM (all outputs registered):
  - IDLE: if FIFO non-empty and busy=0, latch the head into the shadow reg, pop, and go to V1; outputs for the next cycle are nt=1, xi=x1, yi=y1.
  - V1: next cycle nt=0, xi=x2, yi=y2 -> V2.
  - V2: next cycle xi=x3, yi=y3 -> V3.
  - V3: next cycle xi=0, yi=0, clear the timeout counter -> WAIT_HI.
  - WAIT_HI: if busy=1, go to WAIT_LO. Otherwise increment the counter; at BUSY_TIMEOUT, set timeout_err and go to IDLE.
  - WAIT_LO: if busy=0, go to IDLE.
- busy is ignored in V1..V3.
- Timing:
  - Latency from push (edge k) into an empty FIFO with engine idle: nt high in the cycle after edge k+1.
  - Back-to-back triangles are separated by at least the engine busy window plus 1 IDLE cycle.
- Vertices are forwarded unmodified. Degenerate or collinear triangles are not filtered.
- timeout_err clears only on reset.

Optional Feature:
- Macro: TRI_FEEDER_STATS_EN.
- Defined:
  - Adds input po (1 bit) and outputs tri_cnt[15:0] and pix_cnt[15:0].
  - tri_cnt increments on each IDLE->V1 transition.
  - pix_cnt increments on each cycle po=1.
  - Both wrap at 16 bits and reset to 0.
- Undefined: no po port and no counters; the rest of the behaviour is identical.

Decomposition:
- Package tri_feeder_pkg: FSM state enum (IDLE, V1, V2, V3, WAIT_HI, WAIT_LO), the COORD_W default, triangle field offsets, and a vertex struct {x,y}.
- One sub-module, tri_fifo: parameterized sync FIFO (width 6*COORD_W, DEPTH) with full, empty and count outputs. The FSM stays in the top.

Test Plan:
- Single triangle, packed {0,0,7,0,0,7}, busy held 0:
  - nt=1 with (0,0), then (7,0), then (0,7).
  - xi/yi return to 0.
  - After 255 WAIT_HI cycles, timeout_err=1 and idle=1.
- Same triangle with an engine model (busy=1 for 28 cycles, starting 1 cycle after V3), then a second triangle {1,1,5,2,3,6}:
  - The second nt occurs exactly 1 cycle after busy falls.
  - No timeout_err.
- Push 5 triangles back-to-back with busy=1 constantly (DEPTH=4):
  - in_ready drops after the 4th push; the 5th is held by the producer.
  - fifo_cnt=4 and no nt.
  - When busy drops, bursts issue in FIFO order.
- Push while full on the same edge a pop occurs:
  - The push is refused; fifo_cnt goes 4->3.
  - The triangle is accepted on the next edge.
- Assert reset low during V2:
  - nt, xi and yi go to 0 asynchronously; fifo_cnt=0.
  - After release, no residual vertex is issued.
- With TRI_FEEDER_STATS_EN, 2 triangles and po pulsed 28 times each:
  - tri_cnt=2, pix_cnt=56.

Source files
------------

// File: rtl/tri_feeder_pkg.sv
// Shared types and constants for the triangle vertex feeder.
package tri_feeder_pkg;

  localparam int unsigned COORD_W_DEF = 3;

  // Field index within a packed triangle {x1,y1,x2,y2,x3,y3}; bit offset = index * COORD_W.
  localparam int unsigned F_X1 = 5;
  localparam int unsigned F_Y1 = 4;
  localparam int unsigned F_X2 = 3;
  localparam int unsigned F_Y2 = 2;
  localparam int unsigned F_X3 = 1;
  localparam int unsigned F_Y3 = 0;

  localparam int unsigned TRI_FIELDS = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    V1      = 3'd1,
    V2      = 3'd2,
    V3      = 3'd3,
    WAIT_HI = 3'd4,
    WAIT_LO = 3'd5
  } state_t;

  typedef struct packed {
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
  } vertex_t;

endpackage

// File: rtl/tri_fifo.sv
// Synchronous FIFO of packed triangles; pointers wrap modulo DEPTH (power of 2).
module tri_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A push while full is refused even when a pop happens on the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tri_vertex_feeder.sv
// Buffers whole triangles and issues each as an nt-flagged 3-cycle vertex burst paced by busy.
// Optional statistics (po input, tri_cnt/pix_cnt outputs) enabled by TRI_FEEDER_STATS_EN.
module tri_vertex_feeder
  import tri_feeder_pkg::*;
#(
  parameter int unsigned COORD_W      = COORD_W_DEF,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned BUSY_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [TRI_FIELDS*COORD_W-1:0] in_tri,
  input  logic                          busy,
  output logic                          nt,
  output logic [COORD_W-1:0]            xi,
  output logic [COORD_W-1:0]            yi,
  output logic [$clog2(DEPTH):0]        fifo_cnt,
  output logic                          idle,
  output logic                          timeout_err
`ifdef TRI_FEEDER_STATS_EN
  ,
  input  logic                          po,
  output logic [15:0]                   tri_cnt,
  output logic [15:0]                   pix_cnt
`endif
);

  localparam int unsigned TRI_W  = TRI_FIELDS * COORD_W;
  localparam logic [7:0]  TO_LIM = 8'(BUSY_TIMEOUT - 1);

  state_t           state;
  logic [TRI_W-1:0] head;
  logic [TRI_W-1:0] tri_q;
  logic [7:0]       to_cnt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  function automatic logic [COORD_W-1:0] fld(input logic [TRI_W-1:0] t, input int unsigned idx);
    return t[idx*COORD_W +: COORD_W];
  endfunction

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && !empty && !busy;
  assign idle     = (state == IDLE) && empty;

  tri_fifo #(
    .WIDTH (TRI_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (in_tri),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  // Vertex 1 comes straight from the FIFO head; vertices 2 and 3 from the shadow copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      tri_q       <= '0;
      nt          <= 1'b0;
      xi          <= '0;
      yi          <= '0;
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tri_q <= head;
            nt    <= 1'b1;
            xi    <= fld(head, F_X1);
            yi    <= fld(head, F_Y1);
            state <= V1;
          end
        end
        V1: begin
          nt    <= 1'b0;
          xi    <= fld(tri_q, F_X2);
          yi    <= fld(tri_q, F_Y2);
          state <= V2;
        end
        V2: begin
          xi    <= fld(tri_q, F_X3);
          yi    <= fld(tri_q, F_Y3);
          state <= V3;
        end
        V3: begin
          xi     <= '0;
          yi     <= '0;
          to_cnt <= '0;
          state  <= WAIT_HI;
        end
        WAIT_HI: begin
          if (busy) begin
            state <= WAIT_LO;
          end else if (to_cnt == TO_LIM) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        WAIT_LO: begin
          if (!busy) begin
            state <= IDLE;
          end
        end
        default: begin
          nt    <= 1'b0;
          xi    <= '0;
          yi    <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef TRI_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tri_cnt <= '0;
      pix_cnt <= '0;
    end else begin
      if (pop) begin
        tri_cnt <= tri_cnt + 16'd1;
      end
      if (po) begin
        pix_cnt <= pix_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tri_vertex_feeder.sv
// Self-checking bench for tri_vertex_feeder: vector table, directed corner cases, randomized scoreboard.
module tb_tri_vertex_feeder;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_tri;
  logic        busy;
  logic        nt;
  logic [2:0]  xi;
  logic [2:0]  yi;
  logic [2:0]  fifo_cnt;
  logic        idle;
  logic        timeout_err;
`ifdef TRI_FEEDER_STATS_EN
  logic        po;
  logic [15:0] tri_cnt;
  logic [15:0] pix_cnt;
`endif

  int passed = 0;
  int total  = 0;

  tri_vertex_feeder #(
    .COORD_W      (3),
    .DEPTH        (DEPTH),
    .BUSY_TIMEOUT (255)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_tri      (in_tri),
    .busy        (busy),
    .nt          (nt),
    .xi          (xi),
    .yi          (yi),
    .fifo_cnt    (fifo_cnt),
    .idle        (idle),
    .timeout_err (timeout_err)
`ifdef TRI_FEEDER_STATS_EN
    ,
    .po          (po),
    .tri_cnt     (tri_cnt),
    .pix_cnt     (pix_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] tri_in;
    int          ex[3];
    int          ey[3];
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic push_one(input logic [17:0] t);
    in_valid = 1'b1;
    in_tri   = t;
    tick();
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for nt, checks the three vertices and trailing zeros, then plays a busy window.
  task automatic expect_burst(input string tag, input int x1, input int y1, input int x2,
                              input int y2, input int x3, input int y3, input int blen);
    int n = 0;
    while (!nt && n < 300) begin
      tick();
      n++;
    end
    chk({tag, " nt"}, int'(nt), 1);
    chk({tag, " x1"}, int'(xi), x1);
    chk({tag, " y1"}, int'(yi), y1);
    tick();
    chk({tag, " nt v2"}, int'(nt), 0);
    chk({tag, " x2"}, int'(xi), x2);
    chk({tag, " y2"}, int'(yi), y2);
    tick();
    chk({tag, " x3"}, int'(xi), x3);
    chk({tag, " y3"}, int'(yi), y3);
    tick();
    chk({tag, " x end"}, int'(xi), 0);
    chk({tag, " y end"}, int'(yi), 0);
    busy = 1'b1;
    repeat (blen) tick();
    busy = 1'b0;
  endtask

  function automatic int vx(input logic [17:0] t, input int i);
    return int'((t >> (15 - 6 * i)) & 18'd7);
  endfunction

  function automatic int vy(input logic [17:0] t, input int i);
    return int'((t >> (12 - 6 * i)) & 18'd7);
  endfunction

  task automatic run_random();
    logic [17:0] q[$];
    logic [17:0] cur = '0;
    logic [17:0] drove_tri = '0;
    int  bidx = 4;
    int  busy_left = 0;
    int  bursts = 0;
    int  sz;
    bit  drove = 1'b0;
    bit  ready_prev = 1'b1;
    for (int it = 0; it < 2000; it++) begin
      tick();
      sz = q.size();
      if (nt) begin
        chk("rnd nt outside burst", (bidx >= 4) ? 1 : 0, 1);
        chk("rnd nt with data", (sz > 0) ? 1 : 0, 1);
        if (sz > 0) begin
          cur = q.pop_front();
          bursts++;
        end
        bidx = 0;
      end
      if (drove && ready_prev) q.push_back(drove_tri);
      if (bidx < 3) begin
        chk("rnd xi", int'(xi), vx(cur, bidx));
        chk("rnd yi", int'(yi), vy(cur, bidx));
        chk("rnd nt flag", int'(nt), (bidx == 0) ? 1 : 0);
        bidx++;
      end else if (bidx == 3) begin
        chk("rnd xi zero", int'(xi), 0);
        chk("rnd yi zero", int'(yi), 0);
        busy = 1'b1;
        busy_left = int'($urandom_range(20, 1));
        bidx = 4;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) busy = 1'b0;
      end
      chk("rnd fifo_cnt", int'(fifo_cnt), q.size());
      chk("rnd in_ready", int'(in_ready), (q.size() < DEPTH) ? 1 : 0);
      ready_prev = (q.size() < DEPTH);
      drove      = (it < 1500) && ($urandom_range(2, 0) == 0);
      drove_tri  = 18'($urandom);
      in_valid   = drove;
      in_tri     = drove_tri;
    end
    in_valid = 1'b0;
    chk("rnd drained", q.size(), 0);
    chk("rnd bursts seen", (bursts > 0) ? 1 : 0, 1);
    chk("rnd no timeout", int'(timeout_err), 0);
  endtask

  initial begin
    int cnt;
    tbl[0].tri_in = 18'b000_000_111_000_000_111; tbl[0].ex = '{0, 7, 0}; tbl[0].ey = '{0, 0, 7};
    tbl[1].tri_in = 18'b001_001_101_010_011_110; tbl[1].ex = '{1, 5, 3}; tbl[1].ey = '{1, 2, 6};
    tbl[2].tri_in = 18'b011_011_011_011_011_011; tbl[2].ex = '{3, 3, 3}; tbl[2].ey = '{3, 3, 3};
    tbl[3].tri_in = 18'b000_000_010_010_100_100; tbl[3].ex = '{0, 2, 4}; tbl[3].ey = '{0, 2, 4};
    tbl[4].tri_in = 18'b111_110_101_100_011_010; tbl[4].ex = '{7, 5, 3}; tbl[4].ey = '{6, 4, 2};

    reset = 1'b0; in_valid = 1'b0; in_tri = '0; busy = 1'b0;
`ifdef TRI_FEEDER_STATS_EN
    po = 1'b0;
`endif
    tick();
    chk("reset nt", int'(nt), 0);
    chk("reset xi", int'(xi), 0);
    chk("reset yi", int'(yi), 0);
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset fifo_cnt", int'(fifo_cnt), 0);
    chk("reset idle", int'(idle), 1);
    chk("reset timeout_err", int'(timeout_err), 0);
    tick();
    reset = 1'b1;

    // Single triangle, busy never rises: burst, then timeout after 255 WAIT_HI cycles.
    push_one(tbl[0].tri_in);
    chk("t1 fifo_cnt after push", int'(fifo_cnt), 1);
    tick();
    chk("t1 nt", int'(nt), 1);
    chk("t1 x1", int'(xi), 0);
    chk("t1 y1", int'(yi), 0);
    chk("t1 fifo_cnt after pop", int'(fifo_cnt), 0);
    tick();
    chk("t1 nt low", int'(nt), 0);
    chk("t1 x2", int'(xi), 7);
    chk("t1 y2", int'(yi), 0);
    tick();
    chk("t1 x3", int'(xi), 0);
    chk("t1 y3", int'(yi), 7);
    tick();
    chk("t1 x zero", int'(xi), 0);
    chk("t1 y zero", int'(yi), 0);
    repeat (254) tick();
    chk("t1 no timeout yet", int'(timeout_err), 0);
    tick();
    chk("t1 timeout_err", int'(timeout_err), 1);
    chk("t1 idle", int'(idle), 1);
    repeat (3) tick();
    chk("t1 timeout sticky", int'(timeout_err), 1);

    // Engine model with 28-cycle busy window; second triangle follows one IDLE cycle after busy falls.
    do_reset();
    chk("t2 timeout cleared", int'(timeout_err), 0);
    push_one(tbl[0].tri_in);
    tick();
    chk("t2 nt", int'(nt), 1);
    in_valid = 1'b1;
    in_tri   = tbl[1].tri_in;
    tick();
    in_valid = 1'b0;
    chk("t2 x2", int'(xi), 7);
    chk("t2 queued second", int'(fifo_cnt), 1);
    tick();
    tick();
    busy = 1'b1;
    cnt = 0;
    for (int i = 0; i < 28; i++) begin
      tick();
      if (nt) cnt++;
    end
    busy = 1'b0;
    chk("t2 no nt while busy", cnt, 0);
    tick();
    chk("t2 idle gap", int'(nt), 0);
    tick();
    chk("t2 nt after busy fall", int'(nt), 1);
    expect_burst("t2 second", 1, 1, 5, 2, 3, 6, 28);
    tick();
    tick();
    chk("t2 no timeout", int'(timeout_err), 0);
    chk("t2 idle", int'(idle), 1);

    // Vector table: each triangle forwarded unmodified, degenerate ones included.
    for (int i = 0; i < 5; i++) begin
      push_one(tbl[i].tri_in);
      expect_burst($sformatf("vec%0d", i), tbl[i].ex[0], tbl[i].ey[0], tbl[i].ex[1],
                   tbl[i].ey[1], tbl[i].ex[2], tbl[i].ey[2], 4);
    end
    tick();
    tick();
    chk("vec idle", int'(idle), 1);

    // Fill FIFO with busy held high; the 5th push is refused on the edge that pops.
    do_reset();
    busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_tri   = tbl[i].tri_in;
      tick();
      chk($sformatf("fill cnt %0d", i), int'(fifo_cnt), i + 1);
    end
    chk("fill in_ready low", int'(in_ready), 0);
    in_tri = tbl[4].tri_in;
    tick();
    chk("fill held cnt", int'(fifo_cnt), 4);
    chk("fill held nt", int'(nt), 0);
    repeat (3) tick();
    chk("fill still no nt", int'(nt), 0);
    busy = 1'b0;
    tick();
    chk("full pop nt", int'(nt), 1);
    chk("full pop cnt 4->3", int'(fifo_cnt), 3);
    chk("full pop x1", int'(xi), 0);
    chk("full pop in_ready", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("late push accepted", int'(fifo_cnt), 4);
    chk("full x2", int'(xi), 7);
    tick();
    tick();
    busy = 1'b1;
    repeat (5) tick();
    busy = 1'b0;
    for (int i = 1; i < 5; i++) begin
      expect_burst($sformatf("order%0d", i), tbl[i].ex[0], tbl[i].ey[0], tbl[i].ex[1],
                   tbl[i].ey[1], tbl[i].ex[2], tbl[i].ey[2], 5);
    end
    tick();
    tick();
    chk("order drained", int'(fifo_cnt), 0);

    // Asynchronous reset during V2 aborts the burst and empties the FIFO.
    do_reset();
    push_one(tbl[1].tri_in);
    tick();
    in_valid = 1'b1;
    in_tri   = tbl[2].tri_in;
    tick();
    in_valid = 1'b0;
    chk("abort in V2 x2", int'(xi), 5);
    chk("abort queued", int'(fifo_cnt), 1);
    #2 reset = 1'b0;
    #1;
    chk("abort nt", int'(nt), 0);
    chk("abort xi", int'(xi), 0);
    chk("abort yi", int'(yi), 0);
    chk("abort fifo_cnt", int'(fifo_cnt), 0);
    tick();
    tick();
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (nt || xi != 3'd0 || yi != 3'd0) cnt++;
    end
    chk("abort no residual", cnt, 0);
    chk("abort idle", int'(idle), 1);

    do_reset();
    run_random();

`ifdef TRI_FEEDER_STATS_EN
    do_reset();
    for (int i = 0; i < 2; i++) begin
      push_one(tbl[i].tri_in);
      expect_burst($sformatf("stats%0d", i), tbl[i].ex[0], tbl[i].ey[0], tbl[i].ex[1],
                   tbl[i].ey[1], tbl[i].ex[2], tbl[i].ey[2], 3);
      for (int p = 0; p < 28; p++) begin
        po = 1'b1;
        tick();
        po = 1'b0;
        tick();
      end
    end
    chk("stats tri_cnt", int'(tri_cnt), 2);
    chk("stats pix_cnt", int'(pix_cnt), 56);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
